// File: rtl/sfx_event_sequencer_if.sv
// Event/sound handshake between the game FSM, the sequencer and the tone generator.
// The sequencer sits on the slave side; the event source / observer uses master.
interface sfx_event_sequencer_if;
   logic win_evt;
   logic die_evt;
   logic win;
   logic die;
   logic busy;

   modport master (
      output win_evt,
      output die_evt,
      input  win,
      input  die,
      input  busy
   );

   modport slave (
      input  win_evt,
      input  die_evt,
      output win,
      output die,
      output busy
   );
endinterface

// File: rtl/sfx_event_sequencer.sv
// Turns one-cycle win/die pulses into timed, mutually exclusive tone-enable levels
// with a silent gap between sounds. Optional macro SFX_BEEP_PATTERN_EN gates win into beeps.
module sfx_event_sequencer #(
   parameter int TONE_CYCLES = 25000000,
   parameter int GAP_CYCLES  = 5000000,
   parameter int BEEP_CYCLES = 2500000
) (
   input logic                 clk,
   input logic                 rst_n,
   sfx_event_sequencer_if.slave bus
);

   localparam int CNT_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   generate
      if (TONE_CYCLES < 2 || GAP_CYCLES < 1 || BEEP_CYCLES < 1) begin : g_bad_params
         $error("sfx_event_sequencer: TONE_CYCLES>=2, GAP_CYCLES>=1, BEEP_CYCLES>=1 required");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PLAY_WIN = 2'd1,
      PLAY_DIE = 2'd2,
      GAP      = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             pend_valid_reg, pend_valid_next;
   logic             pend_die_reg, pend_die_next;
   logic             win_reg, win_next;
   logic             die_reg, die_next;
   logic             busy_reg, busy_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         pend_valid_reg <= 1'b0;
         pend_die_reg   <= 1'b0;
         win_reg        <= 1'b0;
         die_reg        <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         pend_valid_reg <= pend_valid_next;
         pend_die_reg   <= pend_die_next;
         win_reg        <= win_next;
         die_reg        <= die_next;
         busy_reg       <= busy_next;
      end
   end

   // Next-state / counter / pending logic
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg + CNT_W'(1);
      pend_valid_next = pend_valid_reg;
      pend_die_next   = pend_die_reg;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (bus.die_evt) begin
               state_next = PLAY_DIE;
            end else if (bus.win_evt) begin
               state_next = PLAY_WIN;
            end
         end

         PLAY_WIN: begin
            if (bus.die_evt) begin
               state_next = PLAY_DIE;
               cnt_next   = '0;
            end else if (bus.win_evt) begin
               cnt_next = '0;
            end else if (cnt_reg == TONE_LAST) begin
               state_next = GAP;
               cnt_next   = '0;
            end
         end

         PLAY_DIE: begin
            if (bus.die_evt) begin
               cnt_next = '0;
            end else if (cnt_reg == TONE_LAST) begin
               state_next = GAP;
               cnt_next   = '0;
            end
         end

         GAP: begin
            // A pending die is sticky; a pending win can still be upgraded to die.
            if (bus.die_evt) begin
               pend_valid_next = 1'b1;
               pend_die_next   = 1'b1;
            end else if (bus.win_evt && !(pend_valid_reg && pend_die_reg)) begin
               pend_valid_next = 1'b1;
               pend_die_next   = 1'b0;
            end
            if (cnt_reg == GAP_LAST) begin
               cnt_next = '0;
               if (pend_valid_next) begin
                  state_next = pend_die_next ? PLAY_DIE : PLAY_WIN;
               end else begin
                  state_next = IDLE;
               end
               pend_valid_next = 1'b0;
               pend_die_next   = 1'b0;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so they register in step with it.
`ifdef SFX_BEEP_PATTERN_EN
   logic [31:0] beep_div;
   always_comb begin
      beep_div  = 32'(cnt_next) / 32'(BEEP_CYCLES);
      win_next  = (state_next == PLAY_WIN) && !beep_div[0];
      die_next  = (state_next == PLAY_DIE);
      busy_next = (state_next != IDLE);
   end
`else
   always_comb begin
      win_next  = (state_next == PLAY_WIN);
      die_next  = (state_next == PLAY_DIE);
      busy_next = (state_next != IDLE);
   end
`endif

   assign bus.win  = win_reg;
   assign bus.die  = die_reg;
   assign bus.busy = busy_reg;

endmodule
